fwd_hazard_tracker: RTL and testbench

//  Parametrised forwarding and load-use hazard unit for the EX stage.

---
 rtl/fwd_pkg.sv | 24 ++
 rtl/fwd_match_prio.sv | 36 +++
 rtl/fwd_hazard_tracker.sv | 65 ++++++
 tb/tb_fwd_hazard_tracker.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the EX-stage forwarding / load-use hazard tracker.
// Stage entry packing (MSB..LSB): {valid, is_load, rd[REG_ADDR_W-1:0]}.
package fwd_pkg;

  localparam int SEL_REGFILE = 0;   // select value meaning "take operand from register file"
  localparam int ENT_FLAG_W  = 2;   // valid + is_load

  function automatic int sel_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

  function automatic int entry_width(input int addr_w);
    return addr_w + ENT_FLAG_W;
  endfunction

  function automatic int ent_valid_bit(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int ent_load_bit(input int addr_w);
    return addr_w;
  endfunction

endpackage

// File: rtl/fwd_match_prio.sv
// Per-source priority match: nearest tracked writer of src wins and decides the load hazard.
module fwd_match_prio
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W       = 5,
  parameter int NUM_STAGES       = 2,
  parameter int LOAD_READY_STAGE = 2,
  localparam int SEL_W           = sel_width(NUM_STAGES),
  localparam int ENT_W           = entry_width(REG_ADDR_W)
) (
  input  logic [REG_ADDR_W-1:0]             src,
  input  logic [NUM_STAGES-1:0][ENT_W-1:0]  entries,
  output logic [SEL_W-1:0]                  sel,
  output logic                              load_hazard
);

  localparam int VB = ent_valid_bit(REG_ADDR_W);
  localparam int LB = ent_load_bit(REG_ADDR_W);

  logic hit;

  // entries[0] is stage 1 (EX/MEM); scanning upward, the first hit is the nearest writer
  always_comb begin
    sel         = SEL_W'(SEL_REGFILE);
    load_hazard = 1'b0;
    hit         = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (!hit && (src != '0) && entries[k][VB] && (entries[k][REG_ADDR_W-1:0] == src)) begin
        hit         = 1'b1;
        sel         = SEL_W'(k + 1);
        load_hazard = entries[k][LB] && ((k + 1) < LOAD_READY_STAGE);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_tracker.sv
// EX-stage forwarding and load-use hazard unit; tracks in-flight writers in its own
// shift register of post-EX stages and counts load-use stall cycles (saturating).
module fwd_hazard_tracker
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W       = 5,
  parameter int NUM_SRC          = 2,
  parameter int NUM_STAGES       = 2,
  parameter int LOAD_READY_STAGE = 2,
  parameter int CNT_W            = 32,
  localparam int SEL_W           = sel_width(NUM_STAGES)
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_ex_valid,
  input  logic                          i_ex_regwrite,
  input  logic                          i_ex_is_load,
  input  logic [REG_ADDR_W-1:0]         i_ex_rd,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] i_ex_src,
  input  logic                          i_stall,
  input  logic                          i_flush,
  output logic [NUM_SRC*SEL_W-1:0]      o_fwd_sel,
  output logic                          o_stall_req,
  output logic [CNT_W-1:0]              o_stall_count
);

  localparam int ENT_W = entry_width(REG_ADDR_W);

  logic [NUM_STAGES-1:0][ENT_W-1:0] entries;
  logic [ENT_W-1:0]                 ex_entry;
  logic [NUM_SRC-1:0]               haz;

  // writes to r0 are never tracked, so r0 can never be forwarded
  assign ex_entry = {i_ex_valid & i_ex_regwrite & (i_ex_rd != '0), i_ex_is_load, i_ex_rd};

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    fwd_match_prio #(
      .REG_ADDR_W      (REG_ADDR_W),
      .NUM_STAGES      (NUM_STAGES),
      .LOAD_READY_STAGE(LOAD_READY_STAGE)
    ) u_match (
      .src        (i_ex_src[j*REG_ADDR_W +: REG_ADDR_W]),
      .entries    (entries),
      .sel        (o_fwd_sel[j*SEL_W +: SEL_W]),
      .load_hazard(haz[j])
    );
  end

  assign o_stall_req = |haz;

  // freeze beats everything; a stall or flush injects a bubble while older entries advance
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      entries       <= '0;
      o_stall_count <= '0;
    end else if (!i_stall) begin
      if (o_stall_req && (o_stall_count != '1))
        o_stall_count <= o_stall_count + CNT_W'(1);
      entries[0] <= (o_stall_req || i_flush) ? '0 : ex_entry;
      for (int k = 1; k < NUM_STAGES; k++)
        entries[k] <= entries[k-1];
    end
  end

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Bench: default-parameter tracker plus a 3-stage / CNT_W=2 tracker on shared stimulus,
// checked against a queue-style reference model and directed expectations.
module tb_fwd_hazard_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ex_v, ex_rw, ex_ld, stl, fl;
  logic [4:0] ex_rd, s0, s1;
  logic [3:0] sel_a, sel_b;
  logic       stall_a, stall_b;
  logic [31:0] cnt_a;
  logic [1:0]  cnt_b;

  fwd_hazard_tracker dut_a (
    .i_clock(clk), .i_reset(rst), .i_ex_valid(ex_v), .i_ex_regwrite(ex_rw),
    .i_ex_is_load(ex_ld), .i_ex_rd(ex_rd), .i_ex_src({s1, s0}), .i_stall(stl),
    .i_flush(fl), .o_fwd_sel(sel_a), .o_stall_req(stall_a), .o_stall_count(cnt_a));

  fwd_hazard_tracker #(.NUM_STAGES(3), .LOAD_READY_STAGE(3), .CNT_W(2)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_ex_valid(ex_v), .i_ex_regwrite(ex_rw),
    .i_ex_is_load(ex_ld), .i_ex_rd(ex_rd), .i_ex_src({s1, s0}), .i_stall(stl),
    .i_flush(fl), .o_fwd_sel(sel_b), .o_stall_req(stall_b), .o_stall_count(cnt_b));

  typedef struct { bit v; bit [4:0] rd; bit ld; } ent_t;
  ent_t    md[2][1:3];
  int      ns[2]   = '{2, 3};
  int      lrs[2]  = '{2, 3};
  longint  cmax[2] = '{64'hFFFF_FFFF, 64'd3};
  longint  mc[2];
  int      pass = 0, total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // the newest writer of s (smallest stage) is the one left standing after an oldest-first sweep
  function automatic void eval(input int m, input bit [4:0] s, output int sel, output bit haz);
    sel = 0; haz = 0;
    if (s != 0)
      for (int k = ns[m]; k >= 1; k--)
        if (md[m][k].v && md[m][k].rd == s) begin
          sel = k;
          haz = md[m][k].ld && (k < lrs[m]);
        end
  endfunction

  function automatic bit model_stall(input int m);
    int e; bit h0, h1;
    eval(m, s0, e, h0);
    eval(m, s1, e, h1);
    return h0 | h1;
  endfunction

  task automatic drive(input bit v, rw, ld, input bit [4:0] rd, src0, src1,
                       input bit st, f, r);
    @(negedge clk);
    ex_v = v; ex_rw = rw; ex_ld = ld; ex_rd = rd; s0 = src0; s1 = src1;
    stl = st; fl = f; rst = r;
    #1;
  endtask

  task automatic cmp_model();
    int e0, e1; bit h0, h1;
    logic [3:0] os; logic ost; logic [63:0] oc;
    for (int m = 0; m < 2; m++) begin
      eval(m, s0, e0, h0);
      eval(m, s1, e1, h1);
      os  = (m == 0) ? sel_a : sel_b;
      ost = (m == 0) ? stall_a : stall_b;
      oc  = (m == 0) ? 64'(cnt_a) : 64'(cnt_b);
      chk($sformatf("m%0d_sel0", m), 64'(os[1:0]), 64'(e0));
      chk($sformatf("m%0d_sel1", m), 64'(os[3:2]), 64'(e1));
      chk($sformatf("m%0d_stall", m), 64'(ost), 64'(h0 | h1));
      chk($sformatf("m%0d_count", m), oc, 64'(mc[m]));
    end
  endtask

  task automatic tick();
    bit es[2];
    for (int m = 0; m < 2; m++) es[m] = model_stall(m);
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int k = 1; k <= 3; k++) md[m][k] = '{0, 0, 0};
        mc[m] = 0;
      end else if (!stl) begin
        if (es[m] && mc[m] < cmax[m]) mc[m]++;
        for (int k = ns[m]; k >= 2; k--) md[m][k] = md[m][k-1];
        md[m][1].v  = !(es[m] || fl) && ex_v && ex_rw && (ex_rd != 0);
        md[m][1].rd = ex_rd;
        md[m][1].ld = ex_ld;
      end
    end
  endtask

  task automatic step(input bit v, rw, ld, input bit [4:0] rd, src0, src1,
                      input bit st, f, r);
    drive(v, rw, ld, rd, src0, src1, st, f, r);
    cmp_model();
    tick();
  endtask

  initial begin
    // T1: reset held 2 cycles while EX writes r5
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 5, 0, 0, 0, 0, 1);
      tick();
    end
    drive(1, 0, 0, 0, 5, 5, 0, 0, 0);
    chk("t1_sel", 64'(sel_a), 0);
    chk("t1_stall", 64'(stall_a), 0);
    chk("t1_count", 64'(cnt_a), 0);
    cmp_model(); tick();

    // T2: back-to-back ALU writes of r3, nearest stage wins
    step(1, 1, 0, 3, 0, 0, 0, 0, 0);
    step(1, 1, 0, 3, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 3, 0, 0, 0, 0);
    chk("t2_sel0", 64'(sel_a[1:0]), 1);
    chk("t2_sel1", 64'(sel_a[3:2]), 0);
    chk("t2_stall", 64'(stall_a), 0);
    cmp_model(); tick();

    // T3/T4: load r7 then dependent consumer, frozen for 3 cycles mid-stall
    step(1, 1, 1, 7, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 8, 0, 7, 1, 0, 0);
      chk("t4_stall", 64'(stall_a), 1);
      chk("t4_sel1", 64'(sel_a[3:2]), 1);
      chk("t4_count", 64'(cnt_a), 0);
      cmp_model(); tick();
    end
    drive(1, 1, 0, 8, 0, 7, 0, 0, 0);
    chk("t3_stall", 64'(stall_a), 1);
    cmp_model(); tick();
    drive(1, 1, 0, 8, 0, 7, 0, 0, 0);
    chk("t3_sel1", 64'(sel_a[3:2]), 2);
    chk("t3_stall_clr", 64'(stall_a), 0);
    chk("t3_count", 64'(cnt_a), 1);
    cmp_model(); tick();

    // T5: flushed writer of r9 must not forward
    step(1, 1, 0, 9, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 9, 0, 0, 0, 0);
    chk("t5_sel0", 64'(sel_a[1:0]), 0);
    cmp_model(); tick();

    // T6: 3-stage tracker, load ready at stage 3 -> two stall cycles, then saturation
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    step(1, 1, 1, 4, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 4, 0, 0, 0, 0);
    chk("t6_stall1", 64'(stall_b), 1);
    cmp_model(); tick();
    drive(1, 0, 0, 0, 4, 0, 0, 0, 0);
    chk("t6_stall2", 64'(stall_b), 1);
    chk("t6_sel_mid", 64'(sel_b[1:0]), 2);
    cmp_model(); tick();
    drive(1, 0, 0, 0, 4, 0, 0, 0, 0);
    chk("t6_sel", 64'(sel_b[1:0]), 3);
    chk("t6_stall_clr", 64'(stall_b), 0);
    chk("t6_count", 64'(cnt_b), 2);
    cmp_model(); tick();
    step(1, 1, 1, 6, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 6, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 6, 0, 0, 0);
    chk("t6_sat", 64'(cnt_b), 3);
    chk("t6_sel1", 64'(sel_b[3:2]), 3);
    cmp_model(); tick();

    // randomized traffic over a small register window to force frequent matches
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
